// File: rtl/raw_data_slice_pkg.sv
// raw_data_slice_pkg
//   Shared constants for the raw-data slice encode controller:
//   one-hot FSM state encodings, state width and the largest supported
//   slice count.
package raw_data_slice_pkg;

  localparam int STATE_W    = 3;
  localparam int MAX_SLICES = 16;

  localparam logic [STATE_W-1:0] ST_INIT   = 3'b001;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'b010;
  localparam logic [STATE_W-1:0] ST_ENCODE = 3'b100;

endpackage : raw_data_slice_pkg

// File: rtl/raw_data_slice_prio_enc.sv
// raw_data_slice_prio_enc
//   Combinational lowest-set-bit finder over a NUM_SLICES-wide mask.
//   Ports:
//     vec  in   NUM_SLICES  candidate slice mask
//     idx  out  SEL_W       index of the lowest set bit (0 when vec is zero)
//     any  out  1           vec has at least one set bit
module raw_data_slice_prio_enc #(
  parameter int  NUM_SLICES = 4,
  localparam int SEL_W      = $clog2(NUM_SLICES)
) (
  input  logic [NUM_SLICES-1:0] vec,
  output logic [SEL_W-1:0]      idx,
  output logic                  any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int i = NUM_SLICES - 1; i >= 0; i--) begin
      if (vec[i]) idx = SEL_W'(i);
    end
  end

endmodule : raw_data_slice_prio_enc

// File: rtl/raw_data_slice_fsm.sv
// raw_data_slice_fsm
//   Pops one word from the show-ahead raw-data input FIFO and steers its
//   NUM_SLICES sub-word slices, lowest index first and one per cycle, into
//   the raw-data output FIFO via raw_data_sel. Stalls while the output FIFO
//   is full and pulses word_done when the word has been fully consumed.
//
//   Build option: RAW_DATA_SLICE_SKIP_EN
//     defined   - raw_data_in_wstrb selects which slices are emitted; an
//                 all-zero strobe drops the word (pop + word_done, no push).
//     undefined - every slice is emitted; raw_data_in_wstrb is ignored.
//
//   Ports:
//     clk                     in   system clock
//     reset                   in   synchronous, active-high reset
//     raw_data_in_fifo_empty  in   input FIFO empty (head valid when low)
//     raw_data_in_wstrb       in   per-slice valid mask of head word
//     raw_data_in_fifo_pop    out  pop data FIFO
//     raw_data_in_index_pop   out  pop index FIFO
//     raw_data_in_wstrb_pop   out  pop wstrb FIFO
//     raw_data_out_fifo_full  in   output FIFO full
//     raw_data_out_fifo_push  out  write selected slice to output FIFO
//     raw_data_out_fifo_clr   out  clear output FIFO
//     raw_data_out_index_clr  out  clear output index
//     raw_data_sel            out  slice select to datapath mux
//     word_done               out  pulse when the current word is consumed
//     busy                    out  high in any state other than FETCH
module raw_data_slice_fsm
  import raw_data_slice_pkg::*;
#(
  parameter int NUM_SLICES = 4,
  parameter int SEL_W      = $clog2(NUM_SLICES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  raw_data_in_fifo_empty,
  input  logic [NUM_SLICES-1:0] raw_data_in_wstrb,
  output logic                  raw_data_in_fifo_pop,
  output logic                  raw_data_in_index_pop,
  output logic                  raw_data_in_wstrb_pop,
  input  logic                  raw_data_out_fifo_full,
  output logic                  raw_data_out_fifo_push,
  output logic                  raw_data_out_fifo_clr,
  output logic                  raw_data_out_index_clr,
  output logic [SEL_W-1:0]      raw_data_sel,
  output logic                  word_done,
  output logic                  busy
);

  logic [STATE_W-1:0]    state_q;
  logic [STATE_W-1:0]    state_d;
  logic [NUM_SLICES-1:0] mask_q;
  logic [NUM_SLICES-1:0] mask_rem;
  logic [NUM_SLICES-1:0] eff_strobe;
  logic [SEL_W-1:0]      sel_q;
  logic [SEL_W-1:0]      first_idx;
  logic [SEL_W-1:0]      next_idx;
  logic                  first_any;
  logic                  next_any;
  logic                  pop;
  logic                  push;
  logic                  clr;

`ifdef RAW_DATA_SLICE_SKIP_EN
  assign eff_strobe = raw_data_in_wstrb;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^raw_data_in_wstrb;
  assign eff_strobe   = '1;
`endif

  // Slices still owed once the slice currently selected has been pushed.
  assign mask_rem = mask_q & ~(NUM_SLICES'(1) << sel_q);

  raw_data_slice_prio_enc #(.NUM_SLICES(NUM_SLICES)) u_first_enc (
    .vec (eff_strobe),
    .idx (first_idx),
    .any (first_any)
  );

  raw_data_slice_prio_enc #(.NUM_SLICES(NUM_SLICES)) u_next_enc (
    .vec (mask_rem),
    .idx (next_idx),
    .any (next_any)
  );

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    push         = 1'b0;
    clr          = 1'b0;
    word_done    = 1'b0;
    raw_data_sel = '0;
    busy         = 1'b1;
    case (state_q)
      ST_INIT: begin
        clr     = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        busy = 1'b0;
        if (!raw_data_in_fifo_empty) begin
          pop = 1'b1;
          if (first_any) state_d   = ST_ENCODE;
          else           word_done = 1'b1;
        end
      end
      ST_ENCODE: begin
        raw_data_sel = sel_q;
        if (!raw_data_out_fifo_full) begin
          push = 1'b1;
          if (!next_any) begin
            word_done = 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end
      default: begin
        // Corrupted one-hot encoding: recover through INIT, drive nothing.
        state_d = ST_INIT;
      end
    endcase
    // Reset silences every output regardless of the current state.
    if (reset) begin
      pop          = 1'b0;
      push         = 1'b0;
      clr          = 1'b0;
      word_done    = 1'b0;
      raw_data_sel = '0;
      busy         = 1'b0;
    end
  end

  assign raw_data_in_fifo_pop   = pop;
  assign raw_data_in_index_pop  = pop;
  assign raw_data_in_wstrb_pop  = pop;
  assign raw_data_out_fifo_push = push;
  assign raw_data_out_fifo_clr  = clr;
  assign raw_data_out_index_clr = clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      mask_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        mask_q <= eff_strobe;
        sel_q  <= first_idx;
      end else if (push) begin
        mask_q <= mask_rem;
        if (next_any) sel_q <= next_idx;
      end
    end
  end

endmodule : raw_data_slice_fsm

// File: doc/raw_data_slice_fsm.md
Name: raw_data_slice_fsm

Overview:
- Parametrised successor to the fixed 4-slice raw-data encode controller.
- Pops one word (data/index/wstrb) from the raw-data input FIFO.
- Steers NUM_SLICES sub-word slices, one per cycle, into the raw-data output FIFO via raw_data_sel, stalling on output-full.
- Adds strobe-driven slice skipping, an explicit output push, and a per-word completion pulse; pops only when the input is non-empty.

Parameters:
- NUM_SLICES, 4, slices per input word; legal 2..16.
- SEL_W, $clog2(NUM_SLICES), width of raw_data_sel (derived; do not override).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- raw_data_in_fifo_empty  in  1  input FIFO empty (show-ahead FIFO; head word valid when low).
- raw_data_in_wstrb  in  NUM_SLICES  per-slice valid mask of head word.
- raw_data_in_fifo_pop  out  1  pop data FIFO.
- raw_data_in_index_pop  out  1  pop index FIFO.
- raw_data_in_wstrb_pop  out  1  pop wstrb FIFO.
- raw_data_out_fifo_full  in  1  output FIFO full.
- raw_data_out_fifo_push  out  1  write selected slice to output FIFO.
- raw_data_out_fifo_clr  out  1  clear output FIFO.
- raw_data_out_index_clr  out  1  clear output index.
- raw_data_sel  out  SEL_W  slice select to datapath mux.
- word_done  out  1  one-cycle pulse when the current word is fully consumed.
- busy  out  1  high in any state other than FETCH.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- While reset is high:
  - all outputs 0, raw_data_sel 0, internal mask 0;
  - state <= INIT on the next edge.
- State register is one-hot. States: INIT, FETCH, ENCODE.
- INIT (exactly one cycle):
  - raw_data_out_fifo_clr=1, raw_data_out_index_clr=1;
  - next state FETCH.
- FETCH:
  - If raw_data_in_fifo_empty: no pops, stay in FETCH.
  - Else: all three pops =1 for exactly this cycle, and mask_q <= effective strobe.
    - Effective strobe is 0 → word_done=1, stay in FETCH (word dropped, no push).
    - Otherwise → ENCODE, with sel_q = lowest set bit of the effective strobe.
- ENCODE:
  - raw_data_sel = sel_q throughout.
  - If raw_data_out_fifo_full: push=0; hold sel_q and mask_q; stay in ENCODE (stall, unbounded).
  - Else push=1 and mask bit sel_q is cleared:
    - remaining mask zero → word_done=1, next state FETCH;
    - otherwise sel_q <= lowest remaining set bit, stay in ENCODE.
- Ordering: slices are emitted in ascending index order.
- Throughput: a word with k valid slices takes 1+k cycles with no stalls; FETCH and the last ENCODE do not overlap.
- Boundaries:
  - Full deasserting and reasserting on consecutive cycles → exactly one push per non-full ENCODE cycle.
  - Input empty in ENCODE is ignored.
  - Reset mid-ENCODE discards the already-popped word; no further push for it.
  - Illegal or zero one-hot state → INIT.
- raw_data_sel in FETCH/INIT = 0.
- No push is ever issued outside ENCODE.

Optional Feature:
- Macro: RAW_DATA_SLICE_SKIP_EN.
- Defined: effective strobe = raw_data_in_wstrb; zero-strobe slices are skipped, and all-zero words are dropped with word_done.
- Undefined: effective strobe = all ones. Every word emits all NUM_SLICES slices 0..N-1; raw_data_in_wstrb is ignored but the port remains.

Decomposition:
- Package raw_data_slice_pkg holds:
  - one-hot state constants (INIT, FETCH, ENCODE) and the state width;
  - MAX_SLICES=16.
- Sub-module raw_data_slice_prio_enc, parametrised by NUM_SLICES:
  - combinational lowest-set-bit finder;
  - outputs idx[SEL_W] and any.
  - Used for both the initial select and the next select.

Test Plan:
- Reset then idle, input empty → one cycle clr=1 both; then FETCH with no pops, busy=0 indefinitely.
- NUM_SLICES=4, SKIP_EN, wstrb=4'b1111, out never full → pops at T, pushes T+1..T+4 with sel 0,1,2,3, word_done at T+4.
- SKIP_EN, wstrb=4'b1010 → pushes with sel 1 then 3; word_done on the sel 3 push cycle. wstrb=4'b0000 → pop plus word_done same cycle, zero pushes.
- Full asserted for 3 cycles during sel 2 → push=0 and sel held at 2 for 3 cycles; push resumes on the first non-full cycle, no slice lost or duplicated.
- Reset asserted during the sel 1 push → no pushes after reset; INIT clr pulse; next word starts from sel 0.
- SKIP_EN undefined, wstrb=4'b0001, NUM_SLICES=8 → eight pushes, sel 0..7, then word_done.
